aes_round_sequencer: RTL and testbench

//  Iterative AES-128 encrypt controller. Owns the 128b state and round-key registers and sequences an

---
 rtl/aes_round_sequencer.sv | 161 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encrypt controller driving an external single-round datapath.
// Optional abort input enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
  parameter int NR            = 10,
  parameter int ROUND_W       = 4,
  parameter int CLEAR_ON_DONE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic [127:0]       in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic               busy,
  output logic [ROUND_W-1:0] round_idx,
  output logic [127:0]       dp_state,
  output logic [127:0]       dp_key,
  output logic [7:0]         dp_rcon,
  output logic               dp_final,
  input  logic [127:0]       dp_next_state,
  input  logic [127:0]       dp_next_key
`ifdef AES_SEQ_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [ROUND_W-1:0] NR_C = ROUND_W'(NR);

  logic [1:0]         fsm_r;
  logic [1:0]         fsm_nxt_s;
  logic [ROUND_W-1:0] round_r;
  logic [ROUND_W-1:0] round_nxt_s;
  logic [127:0]       state_r;
  logic [127:0]       state_nxt_s;
  logic [127:0]       key_r;
  logic [127:0]       key_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [7:0]         rcon_r;
  logic               final_r;

  function automatic logic [7:0] rcon_f(input logic [ROUND_W-1:0] r);
    case (r)
      ROUND_W'(1):  rcon_f = 8'h01;
      ROUND_W'(2):  rcon_f = 8'h02;
      ROUND_W'(3):  rcon_f = 8'h04;
      ROUND_W'(4):  rcon_f = 8'h08;
      ROUND_W'(5):  rcon_f = 8'h10;
      ROUND_W'(6):  rcon_f = 8'h20;
      ROUND_W'(7):  rcon_f = 8'h40;
      ROUND_W'(8):  rcon_f = 8'h80;
      ROUND_W'(9):  rcon_f = 8'h1b;
      ROUND_W'(10): rcon_f = 8'h36;
      default:      rcon_f = 8'h00;
    endcase
  endfunction

  // Next-state logic for the controller FSM, round counter and data registers
  always_comb begin
    fsm_nxt_s   = fsm_r;
    round_nxt_s = round_r;
    state_nxt_s = state_r;
    key_nxt_s   = key_r;
    case (fsm_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = in_block ^ in_key;
          key_nxt_s   = in_key;
          round_nxt_s = ROUND_W'(1);
          fsm_nxt_s   = ST_ROUND;
        end else begin
          fsm_nxt_s   = ST_IDLE;
        end
      end
      ST_ROUND: begin
        state_nxt_s = dp_next_state;
        key_nxt_s   = dp_next_key;
        if (round_r == NR_C) begin
          fsm_nxt_s   = ST_DONE;
          round_nxt_s = {ROUND_W{1'b0}};
        end else begin
          round_nxt_s = round_r + ROUND_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_nxt_s = ST_IDLE;
          if (CLEAR_ON_DONE != 0) begin
            state_nxt_s = 128'h0;
            key_nxt_s   = 128'h0;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          fsm_nxt_s = ST_DONE;
        end
      end
      default: begin
        fsm_nxt_s   = ST_IDLE;
        round_nxt_s = {ROUND_W{1'b0}};
        state_nxt_s = 128'h0;
        key_nxt_s   = 128'h0;
      end
    endcase
`ifdef AES_SEQ_ABORT_EN
    // Abort discards a block in flight; in IDLE it does not block an accept
    if (abort && (fsm_r != ST_IDLE)) begin
      fsm_nxt_s   = ST_IDLE;
      round_nxt_s = {ROUND_W{1'b0}};
      state_nxt_s = 128'h0;
      key_nxt_s   = 128'h0;
    end else begin
      fsm_nxt_s   = fsm_nxt_s;
    end
`endif
  end

  // State registers; handshake and datapath-control outputs are registered from next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= ST_IDLE;
      round_r     <= {ROUND_W{1'b0}};
      state_r     <= 128'h0;
      key_r       <= 128'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      rcon_r      <= 8'h00;
      final_r     <= 1'b0;
    end else begin
      fsm_r       <= fsm_nxt_s;
      round_r     <= round_nxt_s;
      state_r     <= state_nxt_s;
      key_r       <= key_nxt_s;
      in_ready_r  <= (fsm_nxt_s == ST_IDLE);
      out_valid_r <= (fsm_nxt_s == ST_DONE);
      busy_r      <= (fsm_nxt_s != ST_IDLE);
      rcon_r      <= (fsm_nxt_s == ST_ROUND) ? rcon_f(round_nxt_s) : 8'h00;
      final_r     <= (fsm_nxt_s == ST_ROUND) && (round_nxt_s == NR_C);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_block = state_r;
  assign busy      = busy_r;
  assign round_idx = round_r;
  assign dp_state  = state_r;
  assign dp_key    = key_r;
  assign dp_rcon   = rcon_r;
  assign dp_final  = final_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer with a golden AES round/key-expansion datapath.
// Define AES_SEQ_ABORT_EN to exercise the abort input.
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round_idx;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [7:0]   dp_rcon;
  logic         dp_final;
  logic [127:0] dp_next_state;
  logic [127:0] dp_next_key;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy), .round_idx(round_idx), .dp_state(dp_state),
    .dp_key(dp_key), .dp_rcon(dp_rcon), .dp_final(dp_final),
    .dp_next_state(dp_next_state), .dp_next_key(dp_next_key)
`ifdef AES_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- golden AES round datapath ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base, b;
    logic [7:0] e;
    r = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  assign dp_next_key   = keyexp(dp_key, dp_rcon);
  assign dp_next_state = aes_round(dp_state, dp_next_key, dp_final);

  // ---------------- checking and scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [127:0] cur_exp;
  int           cyc = 0;
  int           last_acc = 0;
  int           prev_acc = 0;
  int           ov_seen = 0;
  logic         prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepts, checks latency on out_valid rise and data on handshake
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc + 1);
      prev_acc = last_acc;
      last_acc = cyc + 1;
    end
    if (out_valid) ov_seen++;
    if (out_valid && !prev_ov) begin
      if (acc_q.size() > 0) check_eq("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
      else check_eq("spur_out", {127'h0, out_valid}, 128'h0);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) check_eq("ct", out_block, exp_q.pop_front());
      else check_eq("spur_hs", {127'h0, out_valid}, 128'h0);
    end
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
    int n;
    in_block = pt; in_key = k; cur_exp = ct; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("accept_to", 128'(n >= 50), 128'h0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 100) begin
      tick(); n++;
    end
    check_eq("idle_to", 128'(n >= 100), 128'h0);
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (round_idx != 4'(r) && n < 30) begin
      tick(); n++;
    end
    check_eq("round_to", 128'(n >= 30), 128'h0);
  endtask

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_block = 128'h0; in_key = 128'h0;
    out_ready = 1'b1; cur_exp = 128'h0;
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    check_eq("rst_in_ready", {127'h0, in_ready}, 128'h1);
    check_eq("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check_eq("rst_busy", {127'h0, busy}, 128'h0);
    check_eq("rst_round", {124'h0, round_idx}, 128'h0);
    check_eq("rst_rcon", {120'h0, dp_rcon}, 128'h0);
    check_eq("rst_final", {127'h0, dp_final}, 128'h0);
    check_eq("rst_block", out_block, 128'h0);
    check_eq("rst_key", dp_key, 128'h0);
    rst_n = 1'b1;
    tick();

    // FIPS-197 App. B
    send(B_PT, B_KEY, B_CT);
    check_eq("busy_round", {127'h0, busy}, 128'h1);
    wait_idle();

    // FIPS-197 C.1 with per-round control checks
    send(C_PT, C_KEY, C_CT);
    for (int k = 1; k <= 10; k++) begin
      check_eq($sformatf("round_idx%0d", k), {124'h0, round_idx}, 128'(k));
      check_eq($sformatf("rcon%0d", k), {120'h0, dp_rcon}, {120'h0, RCON[k-1]});
      check_eq($sformatf("final%0d", k), {127'h0, dp_final}, 128'(k == 10));
      check_eq($sformatf("in_ready_r%0d", k), {127'h0, in_ready}, 128'h0);
      tick();
    end
    check_eq("done_round_idx", {124'h0, round_idx}, 128'h0);
    check_eq("done_busy", {127'h0, busy}, 128'h1);
    wait_idle();

    // Backpressure: hold out_ready low for 5 cycles of out_valid
    out_ready = 1'b0;
    send(B_PT, B_KEY, B_CT);
    n = 0;
    while (!out_valid && n < 30) begin
      tick(); n++;
    end
    check_eq("ov_to", 128'(n >= 30), 128'h0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_block", out_block, B_CT);
      check_eq("bp_in_ready", {127'h0, in_ready}, 128'h0);
      check_eq("bp_out_valid", {127'h0, out_valid}, 128'h1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_in_ready", {127'h0, in_ready}, 128'h1);
    check_eq("bp_release_ov", {127'h0, out_valid}, 128'h0);
    wait_idle();

    // Back-to-back with in_valid held high
    in_block = B_PT; in_key = B_KEY; cur_exp = B_CT; in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_block = C_PT; in_key = C_KEY; cur_exp = C_CT;
    n = 0;
    while (!in_ready && n < 30) begin
      tick(); n++;
    end
    check_eq("b2b_to", 128'(n >= 30), 128'h0);
    check_eq("b2b_clear", out_block, 128'h0);
    tick();
    in_valid = 1'b0;
    check_eq("b2b_period", 128'(last_acc - prev_acc), 128'd12);
    wait_idle();

    // Reset in the middle of a block
    send(B_PT, B_KEY, B_CT);
    wait_round(5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete(); acc_q.delete();
    check_eq("mrst_in_ready", {127'h0, in_ready}, 128'h1);
    check_eq("mrst_busy", {127'h0, busy}, 128'h0);
    check_eq("mrst_round", {124'h0, round_idx}, 128'h0);
    ov_seen = 0;
    repeat (15) tick();
    check_eq("mrst_no_out", 128'(ov_seen), 128'h0);
    send(B_PT, B_KEY, B_CT);
    wait_idle();

`ifdef AES_SEQ_ABORT_EN
    // Abort at round 3
    send(C_PT, C_KEY, C_CT);
    wait_round(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete(); acc_q.delete();
    check_eq("abort_in_ready", {127'h0, in_ready}, 128'h1);
    check_eq("abort_busy", {127'h0, busy}, 128'h0);
    check_eq("abort_round", {124'h0, round_idx}, 128'h0);
    check_eq("abort_state", out_block, 128'h0);
    ov_seen = 0;
    repeat (15) tick();
    check_eq("abort_no_out", 128'(ov_seen), 128'h0);
    send(B_PT, B_KEY, B_CT);
    wait_idle();

    // Abort in IDLE alongside in_valid must not block the accept
    abort = 1'b1;
    send(C_PT, C_KEY, C_CT);
    abort = 1'b0;
    check_eq("abort_idle_busy", {127'h0, busy}, 128'h1);
    wait_idle();
`endif

    check_eq("sb_empty", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
